// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle for cla_pipe_adder
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined CLA adder/subtractor with valid/ready; CLA_SAT_EN enables saturation
// One BLK*BPS-bit slice is summed per stage; a global advance stalls every stage together.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8,
  parameter int BPS   = 1
) (
  input logic            clock,
  input logic            reset,
  cla_pipe_adder_if.slave bus
);
  localparam int SW   = BLK * BPS;
  localparam int NSTG = WIDTH / SW;

  logic [WIDTH-1:0] a_q  [NSTG];
  logic [WIDTH-1:0] bp_q [NSTG];
  logic [WIDTH-1:0] s_q  [NSTG];
  logic [NSTG-1:0]  c_q;
  logic [NSTG-1:0]  v_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_s  [NSTG];
  logic [WIDTH-1:0] bp_s [NSTG];
  logic [WIDTH-1:0] s_s  [NSTG];
  logic [NSTG-1:0]  c_s;
  logic [NSTG-1:0]  v_s;

  logic [WIDTH-1:0] s_n [NSTG];
  logic [NSTG-1:0]  c_n;
  logic             ovf_n;
  logic             adv;

  // Full lookahead: every carry is a flat sum-of-products of g/p and the group carry-in.
  function automatic logic [BLK:0] cla_carries(input logic [BLK-1:0] g,
                                               input logic [BLK-1:0] p,
                                               input logic           ci);
    logic [BLK:0] c;
    logic         t;
    logic         pr;
    c[0] = ci;
    for (int i = 1; i <= BLK; i++) begin
      t = 1'b0;
      for (int j = 0; j < i; j++) begin
        pr = 1'b1;
        for (int m = j + 1; m < i; m++) pr = pr & p[m];
        t = t | (g[j] & pr);
      end
      pr = 1'b1;
      for (int m = 0; m < i; m++) pr = pr & p[m];
      c[i] = t | (ci & pr);
    end
    return c;
  endfunction

  function automatic logic [1:0] grp_gp(input logic [BLK-1:0] g, input logic [BLK-1:0] p);
    logic [BLK:0] c;
    c = cla_carries(g, p, 1'b0);
    return {c[BLK], &p};
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_src
    if (k == 0) begin : g_first
      assign a_s[k]  = bus.a;
      assign bp_s[k] = bus.sub ? ~bus.b : bus.b;
      assign s_s[k]  = '0;
      assign c_s[k]  = bus.sub | bus.cin;
      assign v_s[k]  = bus.in_valid;
    end else begin : g_next
      assign a_s[k]  = a_q[k-1];
      assign bp_s[k] = bp_q[k-1];
      assign s_s[k]  = s_q[k-1];
      assign c_s[k]  = c_q[k-1];
      assign v_s[k]  = v_q[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] ss;
    logic [BLK-1:0]   ga;
    logic [BLK-1:0]   gb;
    logic [BLK:0]     cv;
    logic [1:0]       gp;
    logic             gc;
    logic             cmsb;
    int               base;
    ovf_n = 1'b0;
    cmsb  = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      ss = s_s[k];
      gc = c_s[k];
      for (int j = 0; j < BPS; j++) begin
        base = k * SW + j * BLK;
        ga   = a_s[k][base +: BLK];
        gb   = bp_s[k][base +: BLK];
        cv   = cla_carries(ga & gb, ga ^ gb, gc);
        ss[base +: BLK] = ga ^ gb ^ cv[BLK-1:0];
        cmsb = cv[BLK-1];
        // Groups inside a stage ripple only through their group G/P terms.
        gp   = grp_gp(ga & gb, ga ^ gb);
        gc   = gp[1] | (gp[0] & gc);
      end
      s_n[k] = ss;
      c_n[k] = gc;
    end
    ovf_n = cmsb ^ c_n[NSTG-1];
`ifdef CLA_SAT_EN
    if (ovf_n) begin
      s_n[NSTG-1] = a_s[NSTG-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign adv           = !v_q[NSTG-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NSTG-1];
  assign bus.sum       = s_q[NSTG-1];
  assign bus.cout      = c_q[NSTG-1];
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSTG; k++) begin
        a_q[k]  <= '0;
        bp_q[k] <= '0;
        s_q[k]  <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        a_q[k]  <= a_s[k];
        bp_q[k] <= bp_s[k];
        s_q[k]  <= s_n[k];
      end
      c_q   <= c_n;
      v_q   <= v_s;
      ovf_q <= ovf_n;
    end
  end
endmodule
